// File: rtl/gc_pkg.sv
// Shared types and helpers for the GarbledCircuit netlist sequencer.
// Header words carry two P-bit fields: hi = [2P-1:P], lo = [P-1:0].
package gc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStream,
    StRun,
    StDone
  } gc_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_XOR     = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned HDR_INIT     = 0;
  localparam int unsigned HDR_INPUT    = 1;
  localparam int unsigned HDR_OUT_DFF  = 2;
  localparam int unsigned HDR_GATE_XOR = 3;

  function automatic logic [31:0] fld_hi(input logic [31:0] w, input int unsigned p);
    return w >> p;
  endfunction

  function automatic logic [31:0] fld_lo(input logic [31:0] w, input int unsigned p);
    return w & ~(32'hffff_ffff << p);
  endfunction

endpackage

// File: rtl/gc_hdr_decode.sv
// Captures the four netlist header words and derives image length, label/table
// counts and the header sanity checks.
module gc_hdr_decode
  import gc_pkg::*;
#(
  parameter int unsigned P  = 16,
  parameter int unsigned CC = 1,
  parameter int unsigned A  = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic [A:0]   idx,
  input  logic [31:0]  word,
  output logic [P:0]   init_size,
  output logic [P:0]   input_size,
  output logic [P-1:0] output_size,
  output logic [P-1:0] dff_size,
  output logic [P-1:0] gate_size,
  output logic [P-1:0] num_xor,
  output logic [32:0]  total,
  output logic         xor_err,
  output logic         size_err,
  output logic [31:0]  n_labels,
  output logic [31:0]  n_tables
);

  localparam logic [A:0] IdxInit    = (A+1)'(HDR_INIT);
  localparam logic [A:0] IdxInput   = (A+1)'(HDR_INPUT);
  localparam logic [A:0] IdxOutDff  = (A+1)'(HDR_OUT_DFF);
  localparam logic [A:0] IdxGateXor = (A+1)'(HDR_GATE_XOR);

  logic [P-1:0] hi, lo, gate_live, xor_live;
  logic         is_gx, hdr3_q;

  assign hi    = P'(fld_hi(word, P));
  assign lo    = P'(fld_lo(word, P));
  assign is_gx = (idx == IdxGateXor);

  // While word 3 is on the bus its fields are not yet registered; use them live.
  assign gate_live = is_gx ? lo : gate_size;
  assign xor_live  = is_gx ? hi : num_xor;
  assign total     = 33'(dff_size) + 33'(gate_live) + 33'd4;
  assign xor_err   = (xor_live > gate_live);
  assign size_err  = (total > (33'd1 << A));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_size   <= '0;
      input_size  <= '0;
      output_size <= '0;
      dff_size    <= '0;
      gate_size   <= '0;
      num_xor     <= '0;
      n_labels    <= '0;
      n_tables    <= '0;
      hdr3_q      <= 1'b0;
    end else begin
      hdr3_q <= cap && is_gx;
      if (cap) begin
        case (idx)
          IdxInit:    init_size  <= (P+1)'(hi) + (P+1)'(lo);
          IdxInput:   input_size <= (P+1)'(hi) + (P+1)'(lo);
          IdxOutDff: begin
            output_size <= lo;
            dff_size    <= hi;
          end
          IdxGateXor: begin
            gate_size <= lo;
            num_xor   <= hi;
          end
          default: ;
        endcase
      end
      if (hdr3_q) begin
        n_labels <= 32'(init_size) + 32'(CC) * 32'(input_size) + 32'd2;
        n_tables <= 32'(CC) * (32'(gate_size) - 32'(num_xor));
      end
    end
  end

endmodule

// File: rtl/gc_netlist_sequencer.sv
// Front-end controller: streams a netlist image from memory into the GarbledCircuit
// core, then watches cid until the core completes or times out.
module gc_netlist_sequencer
  import gc_pkg::*;
#(
  parameter int unsigned P       = 16,
  parameter int unsigned CC      = 1,
  parameter int unsigned S       = 10,
  parameter int unsigned A       = 12,
  parameter int unsigned MAX_CYC = 2**20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  output logic         mem_rd,
  output logic [A-1:0] mem_addr,
  input  logic [31:0]  mem_rdata,
  output logic         gc_start,
  output logic [31:0]  netlist_in,
  input  logic [S-1:0] cid,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err,
  output logic [P:0]   init_size,
  output logic [P:0]   input_size,
  output logic [P-1:0] output_size,
  output logic [P-1:0] dff_size,
  output logic [P-1:0] gate_size,
  output logic [P-1:0] num_xor,
  output logic [31:0]  n_labels,
  output logic [31:0]  n_tables,
  output logic [31:0]  cycles
);

  localparam logic [A:0] IdxGateXor = (A+1)'(HDR_GATE_XOR);

  gc_state_e   state_q, state_d;
  logic [A:0]  cnt_q, cnt_d, cnt_nxt;
  logic [31:0] cycles_q, cycles_d;
  logic [1:0]  err_q, err_d;
  logic [32:0] total;
  logic        xor_err, size_err;

  gc_hdr_decode #(
    .P  (P),
    .CC (CC),
    .A  (A)
  ) u_hdr (
    .clk         (clk),
    .rst         (rst),
    .cap         (state_q == StStream),
    .idx         (cnt_q),
    .word        (mem_rdata),
    .init_size   (init_size),
    .input_size  (input_size),
    .output_size (output_size),
    .dff_size    (dff_size),
    .gate_size   (gate_size),
    .num_xor     (num_xor),
    .total       (total),
    .xor_err     (xor_err),
    .size_err    (size_err),
    .n_labels    (n_labels),
    .n_tables    (n_tables)
  );

  assign cnt_nxt = cnt_q + (A+1)'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    gc_start   = 1'b0;
    netlist_in = '0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        gc_start = 1'b1;
        mem_rd   = 1'b1;
        state_d  = StStream;
      end
      StStream: begin
        netlist_in = mem_rdata;
        cnt_d      = cnt_nxt;
        mem_addr   = cnt_nxt[A-1:0];
        if (cnt_q < IdxGateXor) begin
          mem_rd = 1'b1;
        end else if (cnt_q == IdxGateXor) begin
          if (xor_err) begin
            state_d = StDone;
            err_d   = ERR_XOR;
          end else if (size_err) begin
            state_d = StDone;
            err_d   = ERR_SIZE;
          end else if (total == 33'd4) begin
            state_d = StRun;
          end else begin
            mem_rd = 1'b1;
          end
        end else if (33'(cnt_nxt) < total) begin
          mem_rd = 1'b1;
        end else begin
          state_d = StRun;
        end
        if (!mem_rd) mem_addr = '0;
      end
      StRun: begin
        if (cid == S'(CC)) begin
          state_d = StDone;
        end else if (cycles_q == 32'(MAX_CYC - 1)) begin
          state_d = StDone;
          err_d   = ERR_TIMEOUT;
        end else begin
          cycles_d = cycles_q + 32'd1;
        end
      end
      StDone: begin
        if (go) begin
          state_d  = StStart;
          cnt_d    = '0;
          err_d    = ERR_NONE;
          cycles_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cycles_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == StStart) || (state_q == StStream) || (state_q == StRun);
  assign done   = (state_q == StDone);
  assign err    = err_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_gc_netlist_sequencer.sv
// Randomised self-checking bench for gc_netlist_sequencer against a cycle-level
// model of the image stream, run phase and header arithmetic.
module tb_gc_netlist_sequencer;

  localparam int P       = 16;
  localparam int CC      = 2;
  localparam int S       = 10;
  localparam int A       = 12;
  localparam int MAX_CYC = 40;
  localparam int MEMW    = 1 << A;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic         mem_rd;
  logic [A-1:0] mem_addr;
  logic [31:0]  mem_rdata = '0;
  logic         gc_start;
  logic [31:0]  netlist_in;
  logic [S-1:0] cid;
  logic         busy, done;
  logic [1:0]   err;
  logic [P:0]   init_size, input_size;
  logic [P-1:0] output_size, dff_size, gate_size, num_xor;
  logic [31:0]  n_labels, n_tables, cycles;

  logic [31:0]  mem [MEMW];
  int           n_checks = 0;
  int           n_fail   = 0;

  gc_netlist_sequencer #(
    .P       (P),
    .CC      (CC),
    .S       (S),
    .A       (A),
    .MAX_CYC (MAX_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .gc_start    (gc_start),
    .netlist_in  (netlist_in),
    .cid         (cid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .init_size   (init_size),
    .input_size  (input_size),
    .output_size (output_size),
    .dff_size    (dff_size),
    .gate_size   (gate_size),
    .num_xor     (num_xor),
    .n_labels    (n_labels),
    .n_tables    (n_tables),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_image(input logic [31:0] h0, h1, h2, h3);
    int nbody;
    mem[0] = h0; mem[1] = h1; mem[2] = h2; mem[3] = h3;
    nbody = int'(h2[31:16]) + int'(h3[15:0]);
    for (int i = 0; i < nbody && 4 + i < MEMW; i++) mem[4+i] = $urandom | 32'h1;
  endtask

  // k >= 0: cid reaches CC after k RUN cycles; k < 0: cid never reaches CC.
  task automatic run_image(input int k, input bit go_in_run, input string name);
    logic [31:0] h0, h1, h2, h3, e_nl, e_nt, e_cyc, exp_ns;
    logic [P:0]  e_init, e_inp;
    logic [1:0]  e_err;
    int          dffn, gaten, xorn, total, nstream, end_c;
    h0 = mem[0]; h1 = mem[1]; h2 = mem[2]; h3 = mem[3];
    e_init = {1'b0, h0[31:16]} + {1'b0, h0[15:0]};
    e_inp  = {1'b0, h1[31:16]} + {1'b0, h1[15:0]};
    dffn = int'(h2[31:16]); gaten = int'(h3[15:0]); xorn = int'(h3[31:16]);
    total = 4 + dffn + gaten;
    if (xorn > gaten)    e_err = 2'd1;
    else if (total > MEMW) e_err = 2'd2;
    else if (k < 0)      e_err = 2'd3;
    else                 e_err = 2'd0;
    e_nl = 32'(e_init) + 32'(CC) * 32'(e_inp) + 32'd2;
    e_nt = 32'(CC) * (32'(h3[15:0]) - 32'(h3[31:16]));
    if (e_err == 2'd1 || e_err == 2'd2) begin
      nstream = 4; end_c = 6; e_cyc = 0;
    end else if (e_err == 2'd3) begin
      nstream = total; end_c = 2 + total + MAX_CYC; e_cyc = 32'(MAX_CYC - 1);
    end else begin
      nstream = total; end_c = 3 + total + k; e_cyc = 32'(k);
    end

    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= end_c + 2; c++) begin
      @(negedge clk);
      go  = go_in_run && (c == 3 + total);
      cid = (k >= 0 && e_err == 2'd0 && c >= 2 + total + k) ? S'(CC) : '0;
      exp_ns = (c >= 2 && c <= 1 + nstream) ? mem[c-2] : 32'h0;
      n_checks++;
      if (netlist_in !== exp_ns) begin
        n_fail++;
        $display("FAIL %s netlist_in c=%0d: got %h want %h", name, c, netlist_in, exp_ns);
      end
      n_checks++;
      if (gc_start !== (c == 1) || busy !== (c < end_c) || done !== (c >= end_c)) begin
        n_fail++;
        $display("FAIL %s ctrl c=%0d: got start/busy/done %b%b%b want %b%b%b", name, c,
                 gc_start, busy, done, c == 1, c < end_c, c >= end_c);
      end
      if (mem_rd) begin
        n_checks++;
        if (!(int'(mem_addr) == c - 1 && (int'(mem_addr) <= 4 || int'(mem_addr) < total)
              && c < end_c)) begin
          n_fail++;
          $display("FAIL %s mem_read c=%0d: got addr %0d want addr %0d below total %0d",
                   name, c, mem_addr, c - 1, total);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (err !== 2'd0 || cycles !== 32'd0) begin
          n_fail++;
          $display("FAIL %s clear_on_go: got err %0d cycles %0d want 0 0", name, err, cycles);
        end
      end
    end
    go = 1'b0;
    n_checks++;
    if (err !== e_err || cycles !== e_cyc) begin
      n_fail++;
      $display("FAIL %s result: got err %0d cycles %0d want err %0d cycles %0d",
               name, err, cycles, e_err, e_cyc);
    end
    n_checks++;
    if (init_size !== e_init || input_size !== e_inp || output_size !== h2[15:0] ||
        dff_size !== h2[31:16] || gate_size !== h3[15:0] || num_xor !== h3[31:16]) begin
      n_fail++;
      $display("FAIL %s sizes: got %h %h %h %h %h %h want %h %h %h %h %h %h", name,
               init_size, input_size, output_size, dff_size, gate_size, num_xor,
               e_init, e_inp, h2[15:0], h2[31:16], h3[15:0], h3[31:16]);
    end
    n_checks++;
    if (n_labels !== e_nl || n_tables !== e_nt) begin
      n_fail++;
      $display("FAIL %s counts: got n_labels %0d n_tables %0d want %0d %0d",
               name, n_labels, n_tables, e_nl, e_nt);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({gc_start, mem_rd, mem_addr, netlist_in, busy, done, err, init_size, input_size,
         output_size, dff_size, gate_size, num_xor, n_labels, n_tables, cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs start %b rd %b busy %b done %b err %0d",
               gc_start, mem_rd, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gc_start, mem_rd, busy, done, err, netlist_in, cycles} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got start %b rd %b busy %b done %b err %0d ns %h",
               gc_start, mem_rd, busy, done, err, netlist_in);
    end
  endtask

  task automatic test_basic();
    load_image(32'h0001_0002, 32'h0000_0003, 32'h0001_0002, 32'h0001_0003);
    run_image(5, 1'b0, "basic");
    n_checks++;
    if (n_labels !== 32'd11 || n_tables !== 32'd4 || cycles !== 32'd5 || init_size !== 17'd3)
    begin
      n_fail++;
      $display("FAIL basic_vector: got nl %0d nt %0d cyc %0d init %0d want 11 4 5 3",
               n_labels, n_tables, cycles, init_size);
    end
  endtask

  task automatic test_zero_body();
    load_image(32'h0002_0003, 32'h0004_0005, 32'h0000_0007, 32'h0000_0000);
    run_image(3, 1'b0, "zero_body");
  endtask

  task automatic test_xor_err();
    load_image(32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 32'h0004_0003);
    run_image(-1, 1'b0, "xor_err");
  endtask

  task automatic test_size_err();
    load_image(32'h0001_0001, 32'h0001_0001, {16'd2000, 16'd1}, {16'd0, 16'd2093});
    run_image(-1, 1'b0, "size_err");
  endtask

  task automatic test_max_image();
    load_image(32'h0001_0001, 32'h0001_0001, {16'd2000, 16'd1}, {16'd5, 16'd2092});
    run_image(2, 1'b0, "max_image");
  endtask

  task automatic test_timeout();
    load_image(32'h0003_0001, 32'h0002_0002, 32'h0002_0001, 32'h0001_0002);
    run_image(-1, 1'b0, "timeout");
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, g, x;
    int          k;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom_range(0, 6));
      g = 16'($urandom_range(0, 8));
      x = 16'($urandom_range(0, int'(g)));
      k = $urandom_range(2, 7);
      load_image($urandom, $urandom, {d, 16'($urandom)}, {x, g});
      run_image(k, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_midstream();
    load_image(32'h0001_0002, 32'h0000_0003, 32'h0001_0002, 32'h0001_0003);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gc_start, mem_rd, mem_addr, netlist_in, busy, done, err, init_size, input_size,
         n_labels, cycles} !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: got start %b rd %b ns %h busy %b done %b init %h",
               gc_start, mem_rd, netlist_in, busy, done, init_size);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_image(4, 1'b1, "replay");
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    cid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_body();
    test_xor_err();
    test_basic();
    test_size_err();
    test_max_image();
    test_timeout();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gc_netlist_sequencer.md
# gc_netlist_sequencer

Front-end controller for the `GarbledCircuit` core. It fetches a netlist image from a synchronous-read netlist memory and pulses `start`. It then streams the netlist to `netlist_in` at one word per cycle, in the order the core expects: four header words, then the DFF and gate body. While streaming, it decodes the header sizes. It then monitors `cid` until the core reaches `CC` and reports completion, the run-cycle count and derived dump counts to the host and output collector.

## Interface
Parameters:
- `P`, 16, width of one header field; each header word holds fields `[2P-1:P]` and `[P-1:0]`.
- `CC`, 1, number of sequential clock cycles the circuit is garbled for; completion when `cid == CC`.
- `S`, 10, width of `cid`; must match the core's `S`.
- `A`, 12, netlist memory address width.
- `MAX_CYC`, 2^20, run-phase timeout in cycles.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `go`, in, 1, start request; sampled in IDLE and DONE only.
- `mem_rd`, out, 1, netlist memory read enable.
- `mem_addr`, out, A, netlist memory read address.
- `mem_rdata`, in, 32, read data, valid the cycle after `mem_rd`.
- `gc_start`, out, 1, to core `start`.
- `netlist_in`, out, 32, to core `netlist_in`.
- `cid`, in, S, from core.
- `busy`, out, 1, high in START, STREAM and RUN.
- `done`, out, 1, level; high in DONE.
- `err`, out, 2, error code: 0 ok, 1 num_xor > gate_size, 2 image exceeds memory, 3 timeout.
- `init_size`, out, P+1, header field.
- `input_size`, out, P+1, header field.
- `output_size`, out, P, header field.
- `dff_size`, out, P, header field.
- `gate_size`, out, P, header field.
- `num_xor`, out, P, header field.
- `n_labels`, out, 32, init_size + CC*input_size + 2.
- `n_tables`, out, 32, CC*(gate_size − num_xor).
- `cycles`, out, 32, run-phase cycle count.

## Operation
States: IDLE → START → STREAM → RUN → DONE.
- **IDLE.**
  - All outputs 0.
  - `go` = 1 → START; the word counter clears.
- **START** (exactly 1 cycle).
  - `gc_start` = 1, `mem_rd` = 1, `mem_addr` = 0.
  - `netlist_in` = 0.
  - → STREAM.
- **STREAM.**
  - `netlist_in` = `mem_rdata`, combinational pass-through; word *n* is presented in the *n*-th STREAM cycle (n from 0).
  - Each cycle, issue the read for address n+1 if n+1 < total.
  - Header capture at the clock edge ending the word's cycle:
    - word 0: `init_size` = hi + lo.
    - word 1: `input_size` = hi + lo.
    - word 2: `output_size` = lo, `dff_size` = hi.
    - word 3: `gate_size` = lo, `num_xor` = hi.
  - total = 4 + dff_size + gate_size. While word 3 is presented, total uses the live `mem_rdata` fields for gate/xor.
  - After word total−1 → RUN.
  - If total > 2^A → DONE with err = 2; nothing beyond word 3 is streamed.
  - If num_xor > gate_size → DONE with err = 1.
  - Both error checks are evaluated on word 3.
- **RUN.**
  - `netlist_in` = 0.
  - `cycles` increments each cycle.
  - Sample `cid`; `cid == CC` → DONE, and `cycles` holds.
  - `cycles` == MAX_CYC − 1 without completion → DONE with err = 3.
- **DONE.**
  - `done` = 1; sizes, `n_labels`, `n_tables`, `cycles` and `err` hold.
  - `go` = 1 → START; `err` and `cycles` clear, and the size outputs hold until rewritten.
- **Arithmetic.**
  - Header sums are P+1 bits, no overflow.
  - `n_labels` and `n_tables` are computed in 32 bits, truncated, registered one cycle after word 3 is captured.
- `go` in START, STREAM or RUN is ignored.

## Timing
- Reset (async): state IDLE; every output 0, including `netlist_in`, `mem_addr` and `err`.
- Reset mid-stream or mid-run aborts immediately; no partial `done`.
- Latency:
  - `go` at edge t → `gc_start` in cycle t+1.
  - Word 0 on `netlist_in` in cycle t+2.
  - Last body word in cycle t+1+total.
  - RUN begins at cycle t+2+total.
- `gc_start` is a single-cycle pulse, never asserted outside START.
- `netlist_in` is nonzero only in STREAM.
- Memory accesses:
  - At most one read per cycle.
  - No read at an address ≥ total, except the single address-4 read issued while word 3 is presented.
  - No address ever ≥ 2^A.

## Structure
- Shared package `gc_pkg`:
  - State enum.
  - Error-code constants.
  - Header word index constants (HDR_INIT=0, HDR_INPUT=1, HDR_OUT_DFF=2, HDR_GATE_XOR=3).
  - P-field extract functions.
- One natural sub-module, `gc_hdr_decode`: registers the header fields and computes total, `n_labels`, `n_tables` and the error checks.
- The FSM, address counter and run counter live in the top.

## Test plan
All scenarios use P=16, CC=2.
- Header {0001_0002, 0000_0003, 0001_0002, 0001_0003}, 4 body words, `cid` reaching 2 after 5 RUN cycles → expected:
  - `gc_start` 1 cycle;
  - 8 words in order on consecutive cycles;
  - init 3, input 3, out 2, dff 1, gate 3, xor 1;
  - n_labels 11, n_tables 4;
  - cycles 5, done 1, err 0.
- Zero-length body (dff=0, gate=0) → RUN entered right after word 3; no read at address ≥ 4 except the single address-4 read.
- Word 3 with xor=4, gate=3 → err 1, done, no body words streamed.
- dff+gate > 2^A − 4 → err 2, done.
- `cid` stuck at 0 → err 3 after MAX_CYC cycles.
- Async `rst` pulse mid-STREAM → all outputs 0 that cycle, IDLE; a subsequent `go` replays from word 0. A `go` pulse during RUN → no effect.
